seed_finder: RTL and testbench
==============================

Name: seed_finder

Overview:
- Upstream stage of ExpandFSM in the BLAST pipeline.
- Scans each 512-bit database block against every 22-bit (11-nucleotide) query seed at even bit offsets.
- For every exact seed hit it issues one extension request (start, shiftNo, dataCounter, LocationQ) to the expansion stage, then waits for that stage's stop before issuing the next hit.

Parameters:
NUM_BLOCKS, 1024, number of 512-bit DB blocks scanned per run (1..131072).
SEED_W, 22, seed width in bits. Fixed; also provided as a package constant.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
go  input  1  start a full scan run (accepted only in IDLE)
queryValid  input  1  inQuery valid (captured only in IDLE)
inQuery  input  512  query sequence, 2 bits/nucleotide
dbReq  output  1  DB block read request
dbAddr  output  17  requested block index
dbValid  input  1  inDB valid for requested block
inDB  input  512  database block
start  output  1  extension request, one-cycle pulse
shiftNo  output  9  DB bit offset of hit (even, 0..490)
dataCounter  output  17  block index of hit
LocationQ  output  9  query bit offset of hit (even, 0..490)
stop  input  1  extension finished (from expansion stage)
done  output  1  run complete, held until next accepted go

Behaviour:
- One clock. Reset is synchronous and active-low: rst==0 sampled at posedge clears all outputs, counters and the query-loaded flag, and forces IDLE. This holds in any state, including mid-extension; no stop is awaited after reset.
- Match rule: inDB[s +: 22] == Query[q +: 22], with s,q even in 0..490 (246 positions each).
- State machine:
  - IDLE:
    - queryValid=1 latches Query and sets qLoaded.
    - go=1 with qLoaded: clear done, blk=0, go to FETCH.
    - go=1 without qLoaded: ignored.
  - FETCH: dbReq=1, dbAddr=blk. On dbValid, latch block, clear dbReq, set qPos=0, go to SCAN. dbValid outside FETCH is ignored.
  - SCAN: register the 246-bit hit vector for qPos (all shifts in parallel), go to DRAIN.
  - DRAIN:
    - Vector zero, qPos<490: qPos+=2, go to SCAN.
    - Vector zero, qPos==490, blk<NUM_BLOCKS-1: blk+=1, go to FETCH.
    - Vector zero, qPos==490, blk==NUM_BLOCKS-1: done=1, go to IDLE.
    - Vector nonzero: lowest set index i → shiftNo=2i, LocationQ=qPos, dataCounter=blk; clear bit i; go to ISSUE.
  - ISSUE: if stop==0, start=1 for exactly one cycle, go to WAIT_EXT. If stop==1, hold with start=0.
  - WAIT_EXT: wait for stop==1, then go to SETTLE.
  - SETTLE: one cycle, lets expansion stage clear stop. Then go to DRAIN.
- shiftNo, LocationQ and dataCounter are held stable from ISSUE through SETTLE.
- Hits are issued in order: block ascending, qPos ascending, shift ascending.
- dbReq is never asserted between ISSUE and SETTLE, because the DB port is shared with the expansion stage's load.
- Latency:
  - dbValid → first SCAN: 1 cycle.
  - Per query position without hits: 2 cycles.
  - Per hit: 3 cycles plus extension time.
- Reset values: dbReq=0, dbAddr=0, start=0, shiftNo=0, dataCounter=0, LocationQ=0, done=0.

Optional Feature:
SEED_FINDER_HIT_COUNT_EN:
- Defined: adds output hitCount [31:0]. It is cleared on reset and on accepted go, increments on each start pulse, and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package blast_pkg:
  - Constants: SEED_W=22, BLOCK_W=512, MAX_POS=490, NUM_POS=246.
  - State enum for seed_finder.
- One sub-module, seed_match_vec: combinational 246-bit window comparator taking block, query and qPos.
- Priority encode and control stay in seed_finder.

Test Plan:
- Query all 1s; DB block 0 all 0 except inDB[100+:22]=22'h3FFFFF; NUM_BLOCKS=1 → 246 starts, all with shiftNo=100 and dataCounter=0, LocationQ=0,2,…,490 in order; then done=1.
- Query all 1s, DB all 0, NUM_BLOCKS=2 → dbAddr=0 then 1, no start, done=1 after 2×(1+492) cycles post-dbValid.
- Query inQuery[0+:22]=22'h2AB3C1, rest 0; DB has pattern at shifts 0 and 490, rest 0 → first hits (LocationQ=0, shiftNo=0) and (LocationQ=0, shiftNo=490). Later LocationQ values produce no spurious hits beyond the windows that truly match.
- stop held 1 when entering ISSUE → start stays 0 until stop falls, then a single start pulse. Outputs remain stable through WAIT_EXT/SETTLE while stop pulses.
- rst=0 during WAIT_EXT → next cycle all outputs 0, IDLE. go without a new queryValid is ignored.
- With SEED_FINDER_HIT_COUNT_EN, scenario 1 → hitCount=246. A second go clears it to 0.

Source files
------------

// File: rtl/blast_pkg.sv
// blast_pkg: shared constants and types for the BLAST seed-finding front end.
//   SEED_W  : seed width in bits (11 nucleotides x 2 bits)
//   BLOCK_W : width of one database block and of the query
//   MAX_POS : highest legal even bit offset of a seed window (BLOCK_W - SEED_W)
//   NUM_POS : number of even offsets 0..MAX_POS
package blast_pkg;

  localparam int SEED_W  = 22;
  localparam int BLOCK_W = 512;
  localparam int MAX_POS = 490;
  localparam int NUM_POS = 246;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SCAN,
    S_DRAIN,
    S_ISSUE,
    S_WAIT_EXT,
    S_SETTLE
  } sf_state_e;

  // Extension request handed to the expansion stage.
  typedef struct packed {
    logic [8:0]  shift;  // DB bit offset
    logic [8:0]  loc;    // query bit offset
    logic [16:0] blk;    // DB block index
  } hit_t;

endpackage

// File: rtl/seed_match_vec.sv
// seed_match_vec: combinational window comparator.
//   blk   : 512-bit database block
//   query : 512-bit query sequence
//   q_pos : even query bit offset of the current seed (0..490)
//   hits  : bit i set when blk[2i +: 22] equals query[q_pos +: 22]
module seed_match_vec
  import blast_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk,
  input  logic [BLOCK_W-1:0] query,
  input  logic [8:0]         q_pos,
  output logic [NUM_POS-1:0] hits
);

  logic [SEED_W-1:0] qwin;

  assign qwin = query[q_pos +: SEED_W];

  // All 246 shifts compared in parallel against the same query window.
  for (genvar i = 0; i < NUM_POS; i++) begin : g_win
    assign hits[i] = (blk[2*i +: SEED_W] == qwin);
  end

endmodule

// File: rtl/seed_finder.sv
// seed_finder: scans DB blocks for exact 22-bit seed hits against the query
// and issues one extension request per hit, waiting for stop in between.
//   clk, rst (sync, active-low)
//   go / queryValid / inQuery : run start and query load (IDLE only)
//   dbReq / dbAddr / dbValid / inDB : block fetch handshake
//   start / shiftNo / dataCounter / LocationQ / stop : extension request
//   done : run complete, held until next accepted go
// Optional: define SEED_FINDER_HIT_COUNT_EN to add a saturating hitCount
// output counting start pulses since reset or the last accepted go.
module seed_finder
  import blast_pkg::*;
#(
  parameter int NUM_BLOCKS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic         queryValid,
  input  logic [511:0] inQuery,
  output logic         dbReq,
  output logic [16:0]  dbAddr,
  input  logic         dbValid,
  input  logic [511:0] inDB,
  output logic         start,
  output logic [8:0]   shiftNo,
  output logic [16:0]  dataCounter,
  output logic [8:0]   LocationQ,
  input  logic         stop,
  output logic         done
`ifdef SEED_FINDER_HIT_COUNT_EN
  ,
  output logic [31:0]  hitCount
`endif
);

  sf_state_e state, state_nxt;

  logic [BLOCK_W-1:0] query;
  logic               q_loaded;
  logic [BLOCK_W-1:0] blk_data;
  logic [16:0]        blk;
  logic [8:0]         q_pos;
  logic [NUM_POS-1:0] match_vec;
  logic [NUM_POS-1:0] hit_vec;
  hit_t               hit;
  logic [7:0]         first_idx;
  logic               hit_found;
  logic               last_pos;
  logic               last_blk;
  logic               go_ok;

  seed_match_vec u_match (
    .blk   (blk_data),
    .query (query),
    .q_pos (q_pos),
    .hits  (match_vec)
  );

  assign go_ok     = go && q_loaded;
  assign last_pos  = (q_pos == 9'(MAX_POS));
  assign last_blk  = (blk == 17'(NUM_BLOCKS - 1));
  assign hit_found = |hit_vec;

  // Lowest set bit wins so shifts are issued in ascending order.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (hit_vec[i]) first_idx = 8'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (go_ok) state_nxt = S_FETCH;
      S_FETCH:    if (dbValid) state_nxt = S_SCAN;
      S_SCAN:     state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (hit_found)      state_nxt = S_ISSUE;
        else if (!last_pos) state_nxt = S_SCAN;
        else if (!last_blk) state_nxt = S_FETCH;
        else                state_nxt = S_IDLE;
      end
      // stop still high means the expansion stage has not released yet.
      S_ISSUE:    if (!stop) state_nxt = S_WAIT_EXT;
      S_WAIT_EXT: if (stop) state_nxt = S_SETTLE;
      S_SETTLE:   state_nxt = S_DRAIN;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      query    <= '0;
      q_loaded <= 1'b0;
      blk_data <= '0;
      blk      <= '0;
      q_pos    <= '0;
      hit_vec  <= '0;
      hit      <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (queryValid) begin
            query    <= inQuery;
            q_loaded <= 1'b1;
          end
          if (go_ok) begin
            done <= 1'b0;
            blk  <= '0;
          end
        end
        S_FETCH: begin
          if (dbValid) begin
            blk_data <= inDB;
            q_pos    <= '0;
          end
        end
        S_SCAN: hit_vec <= match_vec;
        S_DRAIN: begin
          if (hit_found) begin
            hit.shift          <= {first_idx, 1'b0};
            hit.loc            <= q_pos;
            hit.blk            <= blk;
            hit_vec[first_idx] <= 1'b0;
          end else if (!last_pos) begin
            q_pos <= q_pos + 9'd2;
          end else if (!last_blk) begin
            blk <= blk + 17'd1;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // dbReq only in FETCH keeps the shared DB port free while an extension runs.
  assign dbReq       = (state == S_FETCH);
  assign dbAddr      = blk;
  assign start       = (state == S_ISSUE) && !stop;
  assign shiftNo     = hit.shift;
  assign LocationQ   = hit.loc;
  assign dataCounter = hit.blk;

`ifdef SEED_FINDER_HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                 hitCount <= '0;
    else if (state == S_IDLE && go_ok)        hitCount <= '0;
    else if (start && hitCount != 32'hFFFFFFFF) hitCount <= hitCount + 32'd1;
  end
`endif

endmodule

// File: tb/tb_seed_finder.sv
// tb_seed_finder: directed bench for seed_finder with NUM_BLOCKS=2.
// A small DB server answers every dbReq in the same cycle from a 2-entry
// block memory; the expansion stage is played by the main thread.
module tb_seed_finder;
  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic         queryValid;
  logic [511:0] inQuery;
  logic         dbReq;
  logic [16:0]  dbAddr;
  logic         dbValid;
  logic [511:0] inDB;
  logic         start;
  logic [8:0]   shiftNo;
  logic [16:0]  dataCounter;
  logic [8:0]   LocationQ;
  logic         stop;
  logic         done;
`ifdef SEED_FINDER_HIT_COUNT_EN
  logic [31:0]  hitCount;
`endif

  logic [511:0] mem [2];
  logic [16:0]  addr_q [$];
  int           n_vec = 0;
  int           n_err = 0;

  localparam logic [21:0] PAT = 22'h2AB3C1;

  seed_finder #(.NUM_BLOCKS(2)) dut (
    .clk(clk), .rst(rst), .go(go), .queryValid(queryValid), .inQuery(inQuery),
    .dbReq(dbReq), .dbAddr(dbAddr), .dbValid(dbValid), .inDB(inDB),
    .start(start), .shiftNo(shiftNo), .dataCounter(dataCounter),
    .LocationQ(LocationQ), .stop(stop), .done(done)
`ifdef SEED_FINDER_HIT_COUNT_EN
    , .hitCount(hitCount)
`endif
  );

  always #5 clk = ~clk;

  // DB server: answers a request in the cycle it is seen.
  always @(negedge clk) begin
    dbValid = dbReq;
    inDB    = mem[dbAddr[0]];
    if (dbReq) addr_q.push_back(dbAddr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_query(input logic [511:0] q);
    @(negedge clk); queryValid = 1'b1; inQuery = q;
    @(negedge clk); queryValid = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start && n < 3000) begin @(negedge clk); n++; end
    if (!start) chk("start_timeout", 64'd0, 64'd1);
  endtask

  // One extension: expansion stage raises stop two cycles later for one cycle.
  task automatic respond();
    @(negedge clk); @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic take_hit(input string tag, input int s, input int l, input int b);
    wait_start();
    chk({tag, "_shift"}, 64'(shiftNo), 64'(s));
    chk({tag, "_locq"},  64'(LocationQ), 64'(l));
    chk({tag, "_blk"},   64'(dataCounter), 64'(b));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_dbReq"}, 64'(dbReq), 64'd0);
    chk({tag, "_dbAddr"}, 64'(dbAddr), 64'd0);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_shift"}, 64'(shiftNo), 64'd0);
    chk({tag, "_blk"}, 64'(dataCounter), 64'd0);
    chk({tag, "_locq"}, 64'(LocationQ), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, extra;
    logic [511:0] q;
    rst = 1'b0; go = 1'b0; queryValid = 1'b0; inQuery = '0; stop = 1'b0;
    mem[0] = '0; mem[1] = '0;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
`ifdef SEED_FINDER_HIT_COUNT_EN
    chk("reset_hitcnt", 64'(hitCount), 64'd0);
`endif
    rst = 1'b1;

    // go with no query loaded must not start a run
    pulse_go();
    extra = 0;
    repeat (4) begin if (dbReq) extra++; @(negedge clk); end
    chk("noquery_go_ignored", 64'(extra), 64'd0);

    // Scenario: all-ones query against all-zero DB, two blocks
    load_query({512{1'b1}});
    addr_q.delete();
    pulse_go();
    n = 0; extra = 0;
    while (!done && n < 3000) begin
      @(negedge clk); n++;
      if (start) extra++;
    end
    chk("zero_db_done", 64'(done), 64'd1);
    chk("zero_db_latency", 64'(n), 64'd986);
    chk("zero_db_starts", 64'(extra), 64'd0);
    chk("zero_db_nreq", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() == 2) begin
      chk("zero_db_addr0", 64'(addr_q[0]), 64'd0);
      chk("zero_db_addr1", 64'(addr_q[1]), 64'd1);
    end
`ifdef SEED_FINDER_HIT_COUNT_EN
    chk("zero_db_hitcnt", 64'(hitCount), 64'd0);
`endif

    // Scenario: single all-ones seed at DB offset 100 in block 0
    mem[0] = '0;
    mem[0][100 +: 22] = 22'h3FFFFF;
    pulse_go();
    chk("s1_done_cleared", 64'(done), 64'd0);
    for (int i = 0; i < 246; i++) begin
      take_hit("s1", 100, 2 * i, 0);
      respond();
    end
    n = 0; extra = 0;
    while (!done && n < 3000) begin
      @(negedge clk); n++;
      if (start) extra++;
    end
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_extra_start", 64'(extra), 64'd0);
`ifdef SEED_FINDER_HIT_COUNT_EN
    chk("s1_hitcnt", 64'(hitCount), 64'd246);
`endif

    // Scenario: pattern at DB shifts 0 and 490, query pattern at offset 0
    mem[0] = '0;
    mem[0][0 +: 22]   = PAT;
    mem[0][490 +: 22] = PAT;
    q = '0;
    q[0 +: 22] = PAT;
    load_query(q);
    pulse_go();
`ifdef SEED_FINDER_HIT_COUNT_EN
    chk("s3_hitcnt_cleared", 64'(hitCount), 64'd0);
`endif
    take_hit("s3_h1", 0, 0, 0);
    respond();
    take_hit("s3_h2", 490, 0, 0);
    respond();

    // Third hit (q=2, s=2) meets stop already high in ISSUE
    stop = 1'b1;
    extra = 0;
    repeat (8) begin @(negedge clk); if (start) extra++; end
    chk("hold_no_start", 64'(extra), 64'd0);
    chk("hold_shift", 64'(shiftNo), 64'd2);
    chk("hold_locq", 64'(LocationQ), 64'd2);
    stop = 1'b0;
    #1;
    chk("release_start", 64'(start), 64'd1);
    @(negedge clk);
    chk("single_pulse", 64'(start), 64'd0);
    @(negedge clk);
    chk("wait_shift", 64'(shiftNo), 64'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("settle_shift", 64'(shiftNo), 64'd2);
    chk("settle_locq", 64'(LocationQ), 64'd2);
    chk("settle_start", 64'(start), 64'd0);

    // Fourth hit (q=4, s=4); reset lands while waiting on the extension
    take_hit("s3_h4", 4, 4, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outs("midrst");
`ifdef SEED_FINDER_HIT_COUNT_EN
    chk("midrst_hitcnt", 64'(hitCount), 64'd0);
`endif
    rst = 1'b1;

    // Query-loaded flag was cleared, so this go is ignored
    pulse_go();
    extra = 0;
    repeat (5) begin if (dbReq || start) extra++; @(negedge clk); end
    chk("postrst_go_ignored", 64'(extra), 64'd0);
    chk("postrst_done", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
